// File: rtl/pattern_serializer.sv
// MSB-first parallel-to-serial source with a valid/ready load port, a cyclic repeat mode,
// an optional idle gap between words and a saturating count of completed words.
module pattern_serializer #(
  parameter int WIDTH = 10,
  parameter int GAP   = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_repeat,
  input  logic             stop,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             word_done,
  output logic [15:0]      words_sent
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] copy_q, copy_d;
  logic             rep_q, rep_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic [15:0]      words_q, words_d;
  logic             bit_out_q, bit_valid_q, word_done_q, busy_q;
  logic             last_s;

  // Next-state and datapath decision for the current cycle
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    copy_d  = copy_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    words_d = words_q;
    rep_d   = rep_q & ~stop;
    last_s  = (cnt_q == CW'(WIDTH - 1));
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          shift_d = load_data;
          copy_d  = load_data;
          rep_d   = load_repeat & ~stop;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (!last_s) begin
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + CW'(1);
        end else begin
          words_d = (words_q == 16'hFFFF) ? words_q : words_q + 16'd1;
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = 4'(GAP - 1);
            shift_d = '0;
          end else if (rep_d) begin
            shift_d = copy_q;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
            shift_d = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (rep_d) begin
          state_d = S_SHIFT;
          shift_d = copy_q;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        shift_d = '0;
      end
    endcase
  end

  // State registers; outputs are registered from the next-state values
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      copy_q      <= '0;
      rep_q       <= 1'b0;
      cnt_q       <= '0;
      gap_q       <= 4'd0;
      words_q     <= 16'd0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      copy_q      <= copy_d;
      rep_q       <= rep_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      words_q     <= words_d;
      bit_valid_q <= (state_d == S_SHIFT);
      bit_out_q   <= (state_d == S_SHIFT) & shift_d[WIDTH-1];
      word_done_q <= (state_d == S_SHIFT) && (cnt_d == CW'(WIDTH - 1));
      busy_q      <= (state_d != S_IDLE);
    end
  end

  // Ready is gated by reset so it is low for as long as reset is held
  assign load_ready = reset_n & (state_q == S_IDLE);
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign word_done  = word_done_q;
  assign busy       = busy_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Randomized self-checking bench for pattern_serializer: one instance with GAP=0 and one with GAP=2,
// compared cycle by cycle against an expected stream built from the word, repeat count and gap.
module tb_pattern_serializer;
  localparam int W = 10;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic [1:0]    lv, rep, stp;
  logic [W-1:0]  ld [2];
  wire  [1:0]    lr, bo, bv, bz, wd;
  wire  [15:0]   ws0, ws1;

  int n_checks = 0;
  int n_errors = 0;
  int wm [2];

  pattern_serializer #(.WIDTH(W), .GAP(0)) u_g0 (
    .clock(clock), .reset_n(reset_n), .load_valid(lv[0]), .load_ready(lr[0]),
    .load_data(ld[0]), .load_repeat(rep[0]), .stop(stp[0]), .bit_out(bo[0]),
    .bit_valid(bv[0]), .busy(bz[0]), .word_done(wd[0]), .words_sent(ws0));

  pattern_serializer #(.WIDTH(W), .GAP(2)) u_g2 (
    .clock(clock), .reset_n(reset_n), .load_valid(lv[1]), .load_ready(lr[1]),
    .load_data(ld[1]), .load_repeat(rep[1]), .stop(stp[1]), .bit_out(bo[1]),
    .bit_valid(bv[1]), .busy(bz[1]), .word_done(wd[1]), .words_sent(ws1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input int sel);
    check("idle_valid", 32'(bv[sel]), 32'd0);
    check("idle_bit", 32'(bo[sel]), 32'd0);
    check("idle_busy", 32'(bz[sel]), 32'd0);
    check("idle_ready", 32'(lr[sel]), 32'd1);
    check("idle_done", 32'(wd[sel]), 32'd0);
  endtask

  // Expected stream: n copies of (W data bits MSB first, then gap zero cycles), then idle
  task automatic run_trace(input int sel, input logic [W-1:0] w, input int n, input int stop_k,
                           input int stop_j, input bit hold, input logic [W-1:0] hw);
    int g;
    g = (sel == 1) ? 2 : 0;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < W + g; c++) begin
        logic ev, eb;
        ev = (c < W);
        eb = 1'b0;
        if (ev) eb = w[W-1-c];
        check("bit_valid", 32'(bv[sel]), 32'(ev));
        check("bit_out", 32'(bo[sel]), 32'(eb));
        check("word_done", 32'(wd[sel]), 32'(c == W - 1));
        check("busy", 32'(bz[sel]), 32'd1);
        check("load_ready", 32'(lr[sel]), 32'd0);
        stp[sel] = (k == stop_k) && (c == stop_j);
        if (hold) begin
          lv[sel] = 1'b1;
          ld[sel] = hw;
        end
        tick();
      end
    end
    stp[sel] = 1'b0;
    wm[sel] += n;
    check("words_sent", 32'((sel == 1) ? ws1 : ws0), 32'(wm[sel]));
    check_idle(sel);
  endtask

  task automatic send(input int sel, input logic [W-1:0] w, input bit r, input int n,
                      input int stop_k, input int stop_j, input bit stop_at_load);
    lv[sel]  = 1'b1;
    ld[sel]  = w;
    rep[sel] = r;
    stp[sel] = stop_at_load;
    tick();
    lv[sel]  = 1'b0;
    stp[sel] = 1'b0;
    rep[sel] = 1'($urandom_range(0, 1));
    ld[sel]  = W'($urandom);
    run_trace(sel, w, n, stop_k, stop_j, 1'b0, '0);
  endtask

  initial begin
    logic [W-1:0] pa, pb;
    reset_n = 1'b0;
    lv = 2'b00; rep = 2'b00; stp = 2'b00;
    ld[0] = '0; ld[1] = '0;
    wm[0] = 0; wm[1] = 0;
    #12;
    for (int s = 0; s < 2; s++) begin
      check("rst_ready", 32'(lr[s]), 32'd0);
      check("rst_valid", 32'(bv[s]), 32'd0);
      check("rst_bit", 32'(bo[s]), 32'd0);
      check("rst_busy", 32'(bz[s]), 32'd0);
      check("rst_done", 32'(wd[s]), 32'd0);
    end
    check("rst_words0", 32'(ws0), 32'd0);
    check("rst_words1", 32'(ws1), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("ready_after_rst0", 32'(lr[0]), 32'd1);
    check("ready_after_rst1", 32'(lr[1]), 32'd1);

    pa = 10'b1110011001;
    send(0, pa, 1'b0, 1, -1, 0, 1'b0);
    send(0, pa, 1'b1, 3, 2, 4, 1'b0);
    send(1, 10'b1000000001, 1'b1, 3, 2, 5, 1'b0);

    // Load held high with another word while busy: accepted only on the first idle cycle
    pb = 10'b0101100111;
    lv[0] = 1'b1; ld[0] = pa; rep[0] = 1'b0;
    tick();
    ld[0] = pb;
    run_trace(0, pa, 1, -1, 0, 1'b1, pb);
    tick();
    lv[0] = 1'b0;
    run_trace(0, pb, 1, -1, 0, 1'b0, '0);

    // Reset in the middle of a word
    lv[0] = 1'b1; ld[0] = pb; rep[0] = 1'b0;
    tick();
    lv[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bv[0]), 32'd0);
    check("mid_rst_bit", 32'(bo[0]), 32'd0);
    check("mid_rst_busy", 32'(bz[0]), 32'd0);
    check("mid_rst_ready", 32'(lr[0]), 32'd0);
    check("mid_rst_done", 32'(wd[0]), 32'd0);
    check("mid_rst_words", 32'(ws0), 32'd0);
    wm[0] = 0; wm[1] = 0;
    @(posedge clock);
    #3 reset_n = 1'b1;
    tick();
    check_idle(0);
    send(0, pb, 1'b0, 1, -1, 0, 1'b0);

    // Repeat requested together with stop on the transfer edge
    send(0, pa, 1'b1, 1, -1, 0, 1'b1);
    send(1, pb, 1'b1, 1, -1, 0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      int sel, n, sk, sj;
      bit r, sa;
      logic [W-1:0] w;
      sel = $urandom_range(0, 1);
      w   = W'($urandom);
      r   = 1'($urandom_range(0, 1));
      n   = r ? $urandom_range(1, 3) : 1;
      sa  = r && ($urandom_range(0, 3) == 0);
      if (sa) n = 1;
      sk  = (r && !sa) ? n - 1 : -1;
      sj  = $urandom_range(0, W - 1);
      send(sel, w, r, n, sk, sj, sa);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
Parallel-to-serial bit-stream source that feeds the serial input of the Mealy pattern detector, one bit per clock. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out MSB first with a qualifying valid strobe. It supports one-shot or cyclic (repeat) transmission, an optional idle gap between words, and a sent-word counter for bench and debug visibility.

Parameters:
WIDTH, 10, bits per word; legal range 1..32.
GAP, 0, idle cycles inserted after each word (bit_valid=0, bit_out=0); legal range 0..15.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
load_valid  input  1  load_data/load_repeat are valid
load_ready  output  1  block accepts a word this cycle
load_data  input  WIDTH  word to send; bit WIDTH-1 goes first
load_repeat  input  1  1 = resend the captured word cyclically until stopped
stop  input  1  ends repeat mode after the current word
bit_out  output  1  serial data; feeds detector input i
bit_valid  output  1  bit_out carries a word bit this cycle
busy  output  1  state != IDLE
word_done  output  1  one-cycle pulse coincident with the last bit of each word
words_sent  output  16  count of completed words, saturating

Behaviour:
- One clock, posedge; reset_n is asynchronous, active-low. While reset_n=0: state=IDLE, shift/copy registers=0, bit_out=0, bit_valid=0, word_done=0, busy=0, words_sent=0, repeat latch=0, load_ready=0 (gated). After deassertion: load_ready=1.
- State IDLE: load_ready=1. A transfer occurs on an edge with load_valid=1 and load_ready=1. That edge captures load_data into the shift register and a copy register, captures load_repeat into the repeat latch, clears bit_cnt, and moves to SHIFT.
- State SHIFT: load_ready=0, and load_valid is ignored. bit_valid=1 and bit_out=shift[WIDTH-1], both registered. The first bit appears in the cycle directly after the transfer edge, giving 1 cycle of latency. Each edge shifts left by 1 and increments bit_cnt.
- The cycle with bit_cnt==WIDTH-1 is the last bit. word_done=1 in that cycle. words_sent increments on that edge, saturating at 16'hFFFF with no wrap.
- After the last bit:
  - repeat latch=1 and GAP=0: reload shift from copy. Bit 0 of the next word follows with no bubble.
  - repeat latch=1 and GAP>0: go to GAP for exactly GAP cycles, then reload and return to SHIFT.
  - repeat latch=0 and GAP=0: go to IDLE. load_ready=1 in the next cycle.
  - repeat latch=0 and GAP>0: go to GAP for GAP cycles, then go to IDLE.
- State GAP: bit_valid=0, bit_out=0, load_ready=0, busy=1, gap counter counts down.
- stop: sampled on every edge in any state and clears the repeat latch. The word in progress always completes in full; it is never truncated.
- stop=1 in the same cycle as a transfer: the repeat latch ends 0 (stop wins), so the word is sent once.
- stop in IDLE has no effect.
- WIDTH=1: every SHIFT cycle is a last-bit cycle, so word_done=1 each word.
- Asserting reset_n=0 mid-word aborts immediately. Outputs go to reset values with no further bits and no word_done. The partial word is not counted.
- bit_out=0 whenever bit_valid=0.

Test Plan:
- Reset, GAP=0, load 10'b1110011001 once → bit_valid=1 for exactly 10 cycles starting one cycle after the transfer. bit_out=1,1,1,0,0,1,1,0,0,1. word_done only on the 10th bit. words_sent=1. load_ready=1 the cycle after.
- Repeat with load_repeat=1, pulse stop during word 3 → 30 contiguous valid bits (pattern ×3), 3 word_done pulses, words_sent=3, then IDLE.
- GAP=2, repeat, load 10'b1000000001 → the pattern is followed by 2 cycles of bit_valid=0/bit_out=0 and repeats. word_done period = 12 cycles.
- Hold load_valid=1 with a different word while busy → no capture. The new word is accepted only on the first IDLE cycle, and its bits follow the first word's last bit (GAP=0) after a 1-cycle IDLE bubble.
- Pull reset_n low after bit 4 of a word → bit_valid, bit_out, busy and load_ready drop to 0 immediately (asynchronously). words_sent=0. No word_done. The next load after release sends the full word from bit 0.
- Transfer with load_repeat=1 and stop=1 in the same cycle → the word is sent exactly once and words_sent increments by 1.
